// File: rtl/pattern_tx_1011.sv
// Serial frame transmitter: sends sync 1011 then a zero-stuffed MSB-first payload,
// so the 1011 pattern only ever appears on the line as the sync field.
module pattern_tx_1011 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             out,
    output logic             sync,
    output logic             done
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // Sync bits leave MSB first: 1, 0, 1, 1
    localparam logic [3:0] SYNC_PAT = 4'b1011;

    logic [1:0]       r_state;
    logic [1:0]       r_cnt;
    logic [2:0]       r_hist;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;
    logic             r_out;
    logic             r_sync;
    logic             r_done;
    logic             r_ready;

    logic [1:0]       w_state_nx;
    logic [1:0]       w_cnt_nx;
    logic [2:0]       w_hist_nx;
    logic [WIDTH-1:0] w_shift_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic             w_last_nx;
    logic             w_out_nx;
    logic             w_sync_nx;
    logic             w_done_nx;
    logic             w_pay;

    assign ready = r_ready;
    assign out   = r_out;
    assign sync  = r_sync;
    assign done  = r_done;

    // State and registered line outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_hist  <= 3'b000;
            r_shift <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_out   <= 1'b0;
            r_sync  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hist  <= w_hist_nx;
            r_shift <= w_shift_nx;
            r_idx   <= w_idx_nx;
            r_last  <= w_last_nx;
            r_out   <= w_out_nx;
            r_sync  <= w_sync_nx;
            r_done  <= w_done_nx;
            r_ready <= (w_state_nx == S_IDLE);
        end
    end

    // Next state and the bit to place on the line in the following cycle
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hist_nx  = r_hist;
        w_shift_nx = r_shift;
        w_idx_nx   = r_idx;
        w_last_nx  = r_last;
        w_out_nx   = 1'b0;
        w_sync_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_pay      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_state_nx = S_SYNC;
                    w_cnt_nx   = 2'd0;
                    w_shift_nx = data_in;
                    w_idx_nx   = IDX_W'(WIDTH - 1);
                    w_last_nx  = 1'b0;
                    w_out_nx   = SYNC_PAT[3];
                    w_sync_nx  = 1'b1;
                    w_hist_nx  = {2'b00, SYNC_PAT[3]};
                end
            end
            S_SYNC: begin
                if (r_cnt == 2'd3) begin
                    w_state_nx = S_DATA;
                    w_pay      = 1'b1;
                end else begin
                    w_cnt_nx  = r_cnt + 2'd1;
                    w_out_nx  = SYNC_PAT[2'd2 - r_cnt];
                    w_sync_nx = 1'b1;
                    w_hist_nx = {r_hist[1:0], SYNC_PAT[2'd2 - r_cnt]};
                end
            end
            S_DATA: begin
                if (r_last) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                    w_hist_nx  = 3'b000;
                end else begin
                    w_pay = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // A 101 history would turn into 1011 with a following 1, so a 0 is stuffed first
        if (w_pay) begin
            if (r_hist == 3'b101) begin
                w_out_nx = 1'b0;
            end else begin
                w_out_nx   = r_shift[WIDTH-1];
                w_shift_nx = r_shift << 1;
                if (r_idx == '0) begin
                    w_last_nx = 1'b1;
                end else begin
                    w_idx_nx = r_idx - IDX_W'(1);
                end
            end
            w_hist_nx = {r_hist[1:0], w_out_nx};
        end
    end

endmodule

// File: tb/tb_pattern_tx_1011.sv
// Self-checking bench for pattern_tx_1011: directed and random frames compared
// bit by bit against a queue-based model of the framing and stuffing rules.
module tb_pattern_tx_1011;

    localparam int unsigned W = 8;

    logic         clk;
    logic         clr;
    logic         valid;
    logic [W-1:0] data_in;
    logic         ready;
    logic         out;
    logic         sync;
    logic         done;

    int n_chk;
    int n_fail;

    bit exp_q[$];
    bit obs_q[$];

    pattern_tx_1011 #(.WIDTH(W)) dut (
        .clk     (clk),
        .clr     (clr),
        .valid   (valid),
        .data_in (data_in),
        .ready   (ready),
        .out     (out),
        .sync    (sync),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line for one frame: sync, then payload MSB first, a 0 inserted
    // whenever the last three line bits read 101
    task automatic build_exp(input logic [W-1:0] d);
        exp_q = {1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (exp_q[$-2] == 1'b1 && exp_q[$-1] == 1'b0 && exp_q[$] == 1'b1)
                exp_q.push_back(1'b0);
            exp_q.push_back(d[i]);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out"},   32'(out),   32'd0);
        chk({tag, "_sync"},  32'(sync),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the done cycle
    task automatic send_frame(input logic [W-1:0] d, input bit hold_valid, input string tag);
        int hits;
        int pos;
        build_exp(d);
        valid   = 1'b1;
        data_in = d;
        @(posedge clk);
        obs_q.delete();
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            chk($sformatf("%s_out%0d", tag, j),  32'(out),   32'(exp_q[j]));
            chk($sformatf("%s_sync%0d", tag, j), 32'(sync),  32'(j < 4));
            chk($sformatf("%s_rdy%0d", tag, j),  32'(ready), 32'd0);
            chk($sformatf("%s_done%0d", tag, j), 32'(done),  32'd0);
            obs_q.push_back(out);
            data_in = W'($urandom);
            valid   = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk({tag, "_end_out"},   32'(out),   32'd0);
        chk({tag, "_end_sync"},  32'(sync),  32'd0);
        chk({tag, "_end_ready"}, 32'(ready), 32'd1);
        chk({tag, "_end_done"},  32'(done),  32'd1);
        hits = 0;
        pos  = -1;
        for (int k = 3; k < obs_q.size(); k++) begin
            if (obs_q[k-3] == 1'b1 && obs_q[k-2] == 1'b0 && obs_q[k-1] == 1'b1 && obs_q[k] == 1'b1) begin
                hits++;
                pos = k;
            end
        end
        chk({tag, "_det_hits"}, 32'(hits), 32'd1);
        chk({tag, "_det_pos"},  32'(pos),  32'd3);
        valid   = 1'b0;
        data_in = W'($urandom);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        clk     = 1'b0;
        clr     = 1'b1;
        valid   = 1'b0;
        data_in = '0;

        #2;
        check_idle("in_reset");
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 10; i++) begin
            data_in = W'($urandom);
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        send_frame(8'h00, 1'b0, "f00");
        @(negedge clk);
        check_idle("gap_a");
        send_frame(8'hA5, 1'b0, "fA5");
        @(negedge clk);
        check_idle("gap_b");
        send_frame(8'h55, 1'b0, "f55");
        @(negedge clk);
        check_idle("gap_c");

        // Back-to-back with valid held high throughout
        send_frame(8'hFF, 1'b1, "bFF");
        send_frame(8'h0F, 1'b1, "b0F");
        @(negedge clk);
        check_idle("gap_d");

        // Asynchronous clear mid-payload, away from any clock edge
        build_exp(8'hA5);
        valid   = 1'b1;
        data_in = 8'hA5;
        @(posedge clk);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            chk($sformatf("pre_clr_out%0d", j), 32'(out), 32'(exp_q[j]));
            valid   = 1'b0;
            data_in = W'($urandom);
        end
        #2 clr = 1'b1;
        #1;
        check_idle("async_clr");
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("post_clr%0d", i));
        end
        send_frame(8'h00, 1'b0, "after_clr");

        // Random payloads with random gaps (gap 0 means back-to-back)
        for (int n = 0; n < 24; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle($sformatf("rgap%0d_%0d", n, g));
            end
            send_frame(W'($urandom), 1'($urandom_range(0, 1)), $sformatf("r%0d", n));
        end
        @(negedge clk);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
